instr_fetch_unit: RTL and testbench

Fetch stage directly downstream of the PC incrementer. It takes the current `PC`/`next_PC` pair, runs a request/ready handshake with instruction memory, and registers the returned instruction into the IF/ID pipeline register. It drives the incrementer's `stall` input so the PC advances only when a fetch completes and the decode stage can accept the result. It also handles decode backpressure through a one-entry skid buffer, flushes, and memory-timeout detection.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/instr_fetch_unit_if.sv | 13 +
 rtl/if_skid_buffer.sv | 27 ++
 rtl/instr_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM states and the IF/ID payload.
package fetch_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN} state_t;

  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_ADDR_W-1:0]  next_pc;
  } if_payload_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready bus between the fetch unit and memory.
interface instr_fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic [INSTR_W-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_skid_buffer.sv
// One-entry payload register that parks a fetched instruction while decode is stalled.
module if_skid_buffer
  import fetch_pkg::*;
#(
  parameter type T = if_payload_t
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic unload,
  input  logic clear,
  input  T     din,
  output logic valid,
  output T     dout
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else begin
      if (clear)       valid <= 1'b0;
      else if (load)   valid <= 1'b1;
      else if (unload) valid <= 1'b0;
      if (load && !clear) dout <= din;
    end
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: handshakes with instruction memory, fills the IF/ID register,
// and holds the PC incrementer until each instruction is actually delivered.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int INSTR_W  = DEF_INSTR_W,
  parameter int MAX_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic [ADDR_W-1:0]   next_pc_in,
  output logic                stall_out,
  instr_fetch_unit_if.master  imem,
  input  logic                id_stall,
  input  logic                flush,
  output logic                if_valid,
  output logic [INSTR_W-1:0]  if_instr,
  output logic [ADDR_W-1:0]   if_pc,
  output logic [ADDR_W-1:0]   if_next_pc,
  output logic                fetch_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  next_pc;
  } payload_t;

  state_t            state, state_nxt;
  logic              ld_fetch, ld_skid, unload, skid_vld, waiting;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     wait_cnt;
  payload_t          fetch_data, skid_data;

  assign fetch_data = '{instr: imem.imem_rdata, pc: pc_in, next_pc: next_pc_in};

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    imem.imem_req  = 1'b0;
    imem.imem_addr = '0;
    stall_out      = 1'b1;
    ld_fetch       = 1'b0;
    ld_skid        = 1'b0;
    unload         = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = pc_in;
        // A flushed request that memory has not yet taken must still be drained.
        if (flush) state_nxt = imem.imem_ready ? S_FETCH : S_DRAIN;
        else if (imem.imem_ready) begin
          if (id_stall) begin
            ld_skid   = 1'b1;
            state_nxt = S_HOLD;
          end else begin
            ld_fetch  = 1'b1;
            stall_out = 1'b0;
          end
        end
      end
      S_HOLD: begin
        if (flush) state_nxt = S_FETCH;
        else if (!id_stall) begin
          unload    = 1'b1;
          stall_out = 1'b0;
          state_nxt = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = addr_q;
        if (imem.imem_ready) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address of the request in flight; the incrementer may be redirected during a drain.
  always_ff @(posedge clk) begin
    if (reset)                 addr_q <= '0;
    else if (state == S_FETCH) addr_q <= pc_in;
  end

  if_skid_buffer #(.T(payload_t)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .load   (ld_skid),
    .unload (unload),
    .clear  (flush),
    .din    (fetch_data),
    .valid  (skid_vld),
    .dout   (skid_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      if_valid   <= 1'b0;
      if_instr   <= '0;
      if_pc      <= '0;
      if_next_pc <= '0;
    end else if (flush) begin
      if_valid <= 1'b0;
    end else if (ld_fetch) begin
      if_valid   <= 1'b1;
      if_instr   <= fetch_data.instr;
      if_pc      <= fetch_data.pc;
      if_next_pc <= fetch_data.next_pc;
    end else if (unload) begin
      if_valid   <= 1'b1;
      if_instr   <= skid_data.instr;
      if_pc      <= skid_data.pc;
      if_next_pc <= skid_data.next_pc;
    end else if (!id_stall) begin
      if_valid <= 1'b0;
    end
  end

  assign waiting = imem.imem_req && !imem.imem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (imem.imem_ready)                 wait_cnt <= '0;
      else if (waiting && wait_cnt != WMAX) wait_cnt <= wait_cnt + 1'b1;
      if (waiting && wait_cnt == WMAX - 1'b1) fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboarded bench for instr_fetch_unit with a behavioural PC incrementer and memory.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] pc = 32'd0, npc = 32'd4;
  logic        ready = 1'b0, id_stall = 1'b0, flush = 1'b0;
  logic        stall_out, if_valid, fetch_err;
  logic [31:0] if_instr, if_pc, if_next_pc;
  int          checks = 0, failures = 0;
  logic        stl, req_s, draining = 1'b0;
  logic [31:0] addr_s;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] npc;
  } exp_t;
  exp_t sb[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  assign bus.imem_ready = ready;
  assign bus.imem_rdata = mem_f(bus.imem_addr);

  instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc), .next_pc_in(npc), .stall_out(stall_out),
    .imem(bus), .id_stall(id_stall), .flush(flush), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_next_pc(if_next_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // One clock: sample combinational outputs, push completed fetches, pop on PC advance.
  task automatic tick();
    exp_t e;
    #1;
    stl = stall_out; req_s = bus.imem_req; addr_s = bus.imem_addr;
    if (req_s && ready && !flush && !draining && !reset) sb.push_back('{mem_f(pc), pc, npc});
    if (flush) sb.delete();
    if (flush && req_s && !ready) draining = 1'b1;
    else if (ready) draining = 1'b0;
    @(posedge clk); #1;
    if (!stl && !reset) begin
      checks++;
      if (sb.size() == 0) begin
        failures++; $display("FAIL sb_empty got_pc=%0d exp=no_advance", if_pc);
      end else begin
        e = sb.pop_front();
        if (!(if_valid === 1'b1 && if_instr === e.instr && if_pc === e.pc && if_next_pc === e.npc)) begin
          failures++;
          $display("FAIL sb_ifid got v=%0b i=%h pc=%0d npc=%0d exp v=1 i=%h pc=%0d npc=%0d",
                   if_valid, if_instr, if_pc, if_next_pc, e.instr, e.pc, e.npc);
        end
      end
      pc = pc + 32'd4; npc = pc + 32'd4;
    end
  endtask

  task automatic do_reset(input logic [31:0] p);
    reset = 1'b1; ready = 1'b0; flush = 1'b0; id_stall = 1'b0;
    pc = p; npc = p + 32'd4;
    tick(); tick();
    reset = 1'b0; sb.delete(); draining = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(32'd1000);
    checks++; if (stl !== 1'b1 || req_s !== 1'b0 || addr_s !== 32'd0) begin
      failures++; $display("FAIL rst_comb got stall=%0b req=%0b addr=%0d exp 1 0 0", stl, req_s, addr_s); end
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc !== 32'd0 || if_next_pc !== 32'd0) begin
      failures++; $display("FAIL rst_ifid got v=%0b i=%h pc=%0d npc=%0d exp 0", if_valid, if_instr, if_pc, if_next_pc); end
    checks++; if (fetch_err !== 1'b0 || dut.state !== S_IDLE || dut.skid_vld !== 1'b0) begin
      failures++; $display("FAIL rst_state got err=%0b st=%0d skid=%0b exp 0 0 0", fetch_err, dut.state, dut.skid_vld); end
  endtask

  task automatic test_zero_wait();
    do_reset(32'd1000);
    ready = 1'b1;
    tick();
    checks++; if (req_s !== 1'b0) begin
      failures++; $display("FAIL zw_first_cycle_req got=%0b exp=0", req_s); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (req_s !== 1'b1 || addr_s !== 32'(1000 + 4 * i) || stl !== 1'b0) begin
        failures++; $display("FAIL zw_req got req=%0b addr=%0d stall=%0b exp 1 %0d 0", req_s, addr_s, stl, 1000 + 4 * i); end
      checks++; if (if_pc !== 32'(1000 + 4 * i)) begin
        failures++; $display("FAIL zw_if_pc got=%0d exp=%0d", if_pc, 1000 + 4 * i); end
    end
    ready = 1'b0;
  endtask

  task automatic test_wait_states();
    do_reset(32'd1000);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (stl !== 1'b1 || req_s !== 1'b1 || addr_s !== 32'd1000 || if_valid !== 1'b0) begin
        failures++; $display("FAIL ws_wait got stall=%0b req=%0b addr=%0d v=%0b exp 1 1 1000 0", stl, req_s, addr_s, if_valid); end
    end
    ready = 1'b1;
    tick();
    checks++; if (stl !== 1'b0 || if_valid !== 1'b1 || if_next_pc !== 32'd1004) begin
      failures++; $display("FAIL ws_done got stall=%0b v=%0b npc=%0d exp 0 1 1004", stl, if_valid, if_next_pc); end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset(32'd1000);
    ready = 1'b1;
    tick(); tick();
    id_stall = 1'b1;
    tick();
    checks++; if (stl !== 1'b1 || if_pc !== 32'd1000 || if_valid !== 1'b1 || dut.state !== S_HOLD) begin
      failures++; $display("FAIL bp_capture got stall=%0b pc=%0d v=%0b st=%0d exp 1 1000 1 %0d", stl, if_pc, if_valid, dut.state, S_HOLD); end
    tick();
    checks++; if (req_s !== 1'b0 || stl !== 1'b1 || if_pc !== 32'd1000) begin
      failures++; $display("FAIL bp_hold got req=%0b stall=%0b pc=%0d exp 0 1 1000", req_s, stl, if_pc); end
    id_stall = 1'b0;
    tick();
    checks++; if (stl !== 1'b0 || if_pc !== 32'd1004 || if_valid !== 1'b1) begin
      failures++; $display("FAIL bp_release got stall=%0b pc=%0d v=%0b exp 0 1004 1", stl, if_pc, if_valid); end
    tick();
    checks++; if (req_s !== 1'b1 || addr_s !== 32'd1008) begin
      failures++; $display("FAIL bp_next_req got req=%0b addr=%0d exp 1 1008", req_s, addr_s); end
    ready = 1'b0;
  endtask

  task automatic test_flush_outstanding();
    do_reset(32'd2000);
    tick(); tick();
    flush = 1'b1;
    tick();
    checks++; if (stl !== 1'b1 || req_s !== 1'b1 || dut.state !== S_DRAIN || if_valid !== 1'b0) begin
      failures++; $display("FAIL fo_flush got stall=%0b req=%0b st=%0d v=%0b exp 1 1 %0d 0", stl, req_s, dut.state, if_valid, S_DRAIN); end
    flush = 1'b0; pc = 32'd3000; npc = 32'd3004;
    tick();
    checks++; if (req_s !== 1'b1 || addr_s !== 32'd2000 || stl !== 1'b1) begin
      failures++; $display("FAIL fo_drain got req=%0b addr=%0d stall=%0b exp 1 2000 1", req_s, addr_s, stl); end
    ready = 1'b1;
    tick();
    checks++; if (stl !== 1'b1 || addr_s !== 32'd2000 || if_valid !== 1'b0 || dut.state !== S_FETCH) begin
      failures++; $display("FAIL fo_discard got stall=%0b addr=%0d v=%0b st=%0d exp 1 2000 0 %0d", stl, addr_s, if_valid, dut.state, S_FETCH); end
    tick();
    checks++; if (addr_s !== 32'd3000 || if_pc !== 32'd3000 || stl !== 1'b0) begin
      failures++; $display("FAIL fo_resume got addr=%0d pc=%0d stall=%0b exp 3000 3000 0", addr_s, if_pc, stl); end
    ready = 1'b0;
  endtask

  task automatic test_flush_ready_stall();
    do_reset(32'd4000);
    ready = 1'b1;
    tick(); tick();
    id_stall = 1'b1; flush = 1'b1;
    tick();
    checks++; if (stl !== 1'b1 || if_valid !== 1'b0 || dut.skid_vld !== 1'b0 || dut.state !== S_FETCH) begin
      failures++; $display("FAIL frs got stall=%0b v=%0b skid=%0b st=%0d exp 1 0 0 %0d", stl, if_valid, dut.skid_vld, dut.state, S_FETCH); end
    id_stall = 1'b0; flush = 1'b0;
    tick();
    checks++; if (if_pc !== 32'd4004 || if_valid !== 1'b1) begin
      failures++; $display("FAIL frs_refetch got pc=%0d v=%0b exp 4004 1", if_pc, if_valid); end
    ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset(32'd5000);
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (fetch_err !== (k >= 4)) begin
        failures++; $display("FAIL to_wait%0d got=%0b exp=%0b", k, fetch_err, k >= 4); end
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    checks++; if (fetch_err !== 1'b1 || if_pc !== 32'd5000) begin
      failures++; $display("FAIL to_sticky got err=%0b pc=%0d exp 1 5000", fetch_err, if_pc); end
    do_reset(32'd6000);
    checks++; if (fetch_err !== 1'b0 || req_s !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL to_reset got err=%0b req=%0b v=%0b exp 0 0 0", fetch_err, req_s, if_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_flush_outstanding();
    test_flush_ready_stall();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
